// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state encoding and helpers
package uart_pkg;

   // FSM state encoding shared by transmitter and receiver
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   // Default line setup: 50 MHz clock, 9600 bit/s
   localparam int DEF_CLK_HZ = 50_000_000;
   localparam int DEF_BAUD   = 9600;

   // Frame constants common to both ends of the line
   localparam int   DATA_BITS = 8;
   localparam logic START_LVL = 1'b0;
   localparam logic IDLE_LVL  = 1'b1;

   // Clocks per bit, truncated
   function automatic int calc_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_t_if.sv
// rtl/uart_t_if.sv - byte valid/ready handshake into the transmitter
interface uart_t_if import uart_pkg::*; ();
   logic [DATA_BITS-1:0] in_data;
   logic                 in_valid;
   logic                 in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - small synchronous FIFO with occupancy counter
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   // Refuse writes when full and reads when empty, regardless of the other side
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign rdata = mem[rptr];

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

   // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end
endmodule

// File: rtl/uart_t.sv
// rtl/uart_t.sv - buffered 8N1/8N2 UART transmitter
module uart_t import uart_pkg::*; #(
   parameter int CLK_HZ     = DEF_CLK_HZ,
   parameter int BAUD       = DEF_BAUD,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   uart_t_if.slave  host,
   output logic     q,
   output logic     busy
);
   localparam int             DIV     = calc_div(CLK_HZ, BAUD);
   localparam int             CW      = $clog2(DIV);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);
   localparam logic [2:0]     SB_LAST = 3'(STOP_BITS - 1);

   uart_state_e          state, state_d;
   logic [CW-1:0]        cnt, cnt_d;
   logic [2:0]           bit_idx, bit_idx_d;
   logic [DATA_BITS-1:0] sh, sh_d;
   logic                 q_d;
   logic                 pop;
   logic                 full;
   logic                 empty;
   logic [DATA_BITS-1:0] rdata;
   logic                 bit_end;

   assign host.in_ready = !full;
   assign busy          = (state != IDLE) || !empty;
   assign bit_end       = (cnt == CNT_MAX);

   uart_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (host.in_valid && !full),
      .pop   (pop),
      .wdata (host.in_data),
      .rdata (rdata),
      .full  (full),
      .empty (empty)
   );

   // Next-state, counters and shifter; bit_idx also counts stop bits in STOP
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      bit_idx_d = bit_idx;
      sh_d      = sh;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            cnt_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               sh_d    = rdata;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = DATA;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d     = '0;
               sh_d      = sh >> 1;
               // wraps 7 -> 0, so STOP starts counting stop bits from zero
               bit_idx_d = bit_idx + 1'b1;
               if (bit_idx == 3'd7) state_d = STOP;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_idx == SB_LAST) begin
                  bit_idx_d = '0;
                  if (!empty) begin
                     pop     = 1'b1;
                     sh_d    = rdata;
                     state_d = START;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  bit_idx_d = bit_idx + 1'b1;
               end
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level is decoded from the next state so q lands on the same edge as the state
   always_comb begin
      q_d = IDLE_LVL;
      case (state_d)
         START:   q_d = START_LVL;
         DATA:    q_d = sh_d[0];
         default: q_d = IDLE_LVL;
      endcase
   end

   // State, counters, shift register and the registered line output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         sh      <= '0;
         q       <= IDLE_LVL;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         bit_idx <= bit_idx_d;
         sh      <= sh_d;
         q       <= q_d;
      end
   end
endmodule

// File: tb/tb_uart_t.sv
// tb/tb_uart_t.sv - scoreboard bench for uart_t at DIV = 10
module tb_uart_t;

   logic clk = 1'b0;
   logic rst_n;
   logic q1, busy1, q2, busy2;

   always #5 clk = ~clk;

   uart_t_if if1 ();
   uart_t_if if2 ();

   uart_t #(.CLK_HZ(1_000_000), .BAUD(100_000), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .host  (if1.slave),
      .q     (q1),
      .busy  (busy1)
   );

   uart_t #(.CLK_HZ(1_000_000), .BAUD(100_000), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .host  (if2.slave),
      .q     (q2),
      .busy  (busy2)
   );

   int         n_vec = 0;
   int         n_err = 0;
   int         cyc = 0;
   logic [7:0] exp_q [$];
   int         mon_starts [$];
   int         mon_frames = 0;
   int         mon_ph = 0;
   logic [7:0] mon_sh = '0;
   int         last_push_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Frame decoder on dut1's line: samples mid-bit, pops the scoreboard at each stop bit
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_ph = 0;
      end else if (mon_ph == 0) begin
         if (q1 === 1'b0) begin
            mon_ph = 1;
            mon_starts.push_back(cyc);
         end
      end else begin
         mon_ph++;
         if (mon_ph == 5) begin
            check("start_bit", {31'd0, q1}, 32'd0);
         end else if (mon_ph >= 15 && mon_ph <= 85 && (mon_ph % 10) == 5) begin
            mon_sh = {q1, mon_sh[7:1]};
         end else if (mon_ph == 95) begin
            check("stop_bit", {31'd0, q1}, 32'd1);
            mon_frames++;
            if (exp_q.size() == 0) check("sb_extra_frame", {24'd0, mon_sh}, 32'hFFFF_FFFF);
            else                   check("sb_byte", {24'd0, mon_sh}, {24'd0, exp_q.pop_front()});
            mon_ph = 0;
         end
      end
   end

   // Offer one byte to dut1 ahead of the next edge; valid stays high for the caller to drop
   task automatic push1(input logic [7:0] d);
      @(negedge clk);
      if1.in_valid = 1'b1;
      if1.in_data  = d;
      check("push_ready", {31'd0, if1.in_ready}, 32'd1);
      if (if1.in_ready) exp_q.push_back(d);
      last_push_cyc = cyc + 1;
   endtask

   task automatic wait_idle1(input int bound);
      int n = 0;
      while (busy1 !== 1'b0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (busy1 !== 1'b0) check("idle_timeout", {31'd0, busy1}, 32'd0);
   endtask

   // Cycle-by-cycle line model: frames of start, 8 data LSB first, sb stop bits, then idle
   task automatic line_check(input string tag, input int sel, input logic [7:0] b0,
                             input logic [7:0] b1, input int nfr, input int sb, input int len);
      int         flen;
      int         fr;
      int         slot;
      logic [7:0] b;
      logic       e;
      logic       got;
      flen = (9 + sb) * 10;
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         if (i == 0) begin
            if1.in_valid = 1'b0;
            if2.in_valid = 1'b0;
         end
         fr   = i / flen;
         slot = (i % flen) / 10;
         b    = (fr == 0) ? b0 : b1;
         if (fr >= nfr)     e = 1'b1;
         else if (slot == 0) e = 1'b0;
         else if (slot <= 8) e = b[slot-1];
         else                e = 1'b1;
         got = (sel == 2) ? q2 : q1;
         check(tag, {31'd0, got}, {31'd0, e});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int         bad;
      int         acc;
      int         acc_at_full;
      int         guard;
      int         fr0;
      logic [7:0] nb;
      int         acc_cyc [$];

      rst_n        = 1'b0;
      if1.in_valid = 1'b0;
      if1.in_data  = '0;
      if2.in_valid = 1'b0;
      if2.in_data  = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // reset state and 100 idle cycles
      @(negedge clk);
      check("rst_q", {31'd0, q1}, 32'd1);
      check("rst_ready", {31'd0, if1.in_ready}, 32'd1);
      check("rst_busy", {31'd0, busy1}, 32'd0);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (q1 !== 1'b1 || if1.in_ready !== 1'b1 || busy1 !== 1'b0) bad++;
      end
      check("idle_100", bad, 0);

      // single byte 0xA5: frame begins the edge after the push
      push1(8'hA5);
      @(negedge clk);
      if1.in_valid = 1'b0;
      check("busy_after_push", {31'd0, busy1}, 32'd1);
      line_check("line_a5", 1, 8'hA5, 8'h00, 1, 1, 110);
      check("a5_frames", mon_starts.size(), 1);
      if (mon_starts.size() > 0) check("a5_start_cyc", mon_starts[0], last_push_cyc + 1);
      wait_idle1(50);

      // three back-to-back bytes, no gaps between frames
      mon_starts.delete();
      push1(8'h00);
      fr0 = last_push_cyc;
      push1(8'hFF);
      push1(8'h3C);
      @(negedge clk);
      if1.in_valid = 1'b0;
      wait_idle1(600);
      check("b2b_frames", mon_starts.size(), 3);
      if (mon_starts.size() == 3) begin
         check("b2b_first", mon_starts[0], fr0 + 1);
         check("b2b_gap1", mon_starts[1] - mon_starts[0], 100);
         check("b2b_gap2", mon_starts[2] - mon_starts[1], 100);
         check("b2b_busy_fall", cyc, mon_starts[2] + 100);
      end

      // hold valid high with incrementing bytes
      acc = 0;
      acc_at_full = -1;
      guard = 0;
      nb = 8'h01;
      while (acc < 8 && guard < 2000) begin
         @(negedge clk);
         if1.in_valid = 1'b1;
         if1.in_data  = nb;
         if (if1.in_ready) begin
            exp_q.push_back(nb);
            acc_cyc.push_back(cyc);
            acc++;
            nb++;
         end else if (acc_at_full < 0) begin
            acc_at_full = acc;
         end
         guard++;
      end
      @(negedge clk);
      if1.in_valid = 1'b0;
      check("hold_accepted", acc, 8);
      check("hold_before_full", acc_at_full, 5);
      if (acc_cyc.size() == 8) begin
         check("hold_gap6", acc_cyc[6] - acc_cyc[5], 100);
         check("hold_gap7", acc_cyc[7] - acc_cyc[6], 100);
      end
      wait_idle1(1500);

      // asynchronous reset in the middle of 0x5A's bit 0 with two bytes queued
      push1(8'h5A);
      push1(8'h11);
      push1(8'h22);
      @(negedge clk);
      if1.in_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("pre_rst_q", {31'd0, q1}, 32'd0);
      check("pre_rst_busy", {31'd0, busy1}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_q", {31'd0, q1}, 32'd1);
      check("rst_async_ready", {31'd0, if1.in_ready}, 32'd1);
      check("rst_async_busy", {31'd0, busy1}, 32'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      fr0 = mon_frames;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (q1 !== 1'b1 || busy1 !== 1'b0) bad++;
      end
      check("post_rst_quiet", bad, 0);
      check("post_rst_frames", mon_frames, fr0);

      // two stop bits, 0x81 twice
      @(negedge clk);
      if2.in_valid = 1'b1;
      if2.in_data  = 8'h81;
      check("sb2_ready0", {31'd0, if2.in_ready}, 32'd1);
      @(negedge clk);
      check("sb2_ready1", {31'd0, if2.in_ready}, 32'd1);
      line_check("line_sb2", 2, 8'h81, 8'h81, 2, 2, 240);
      check("sb2_idle_busy", {31'd0, busy2}, 32'd0);

      check("frames_total", mon_frames, 12);
      check("sb_left", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
